// File: rtl/test022_pkg.sv
// test022_pkg: shared state encoding, default parameters and golden-sum helper
package test022_pkg;

    typedef enum logic [1:0] {IDLE, FILL, SUM, CHECK} state_t;

    localparam int N_DEF        = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int EXPECTED_DEF = 1240;

    function automatic int unsigned golden_sum(input int unsigned n);
        int unsigned s;
        s = 0;
        for (int unsigned k = 0; k < n; k++) s += k * k;
        return s;
    endfunction

endpackage

// File: rtl/test022_ram.sv
// test022_ram: single-port synchronous RAM, 1-cycle read, read-during-write returns old data
module test022_ram #(
    parameter int N      = 16,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N];

    // write on we; registered read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/test022_selftest.sv
// test022_selftest: fills a RAM with i*i, sums it back and compares against a golden value
module test022_selftest
    import test022_pkg::*;
#(
    parameter int          N        = N_DEF,
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int unsigned EXPECTED = EXPECTED_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic test_req,
    output logic test_busy,
    output logic test_return
);

    localparam int IW = $clog2(N) + 1;
    localparam int AW = $clog2(N);
    localparam logic [IW-1:0]     LAST  = IW'(N - 1);
    localparam logic [IW-1:0]     NI    = IW'(N);
    localparam logic [DATA_W-1:0] EXP_W = DATA_W'(EXPECTED);

    state_t            state, state_nx;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] acc, rdata, wdata;
    logic [2*IW-1:0]   sq;
    logic              we;

    assign sq        = {{IW{1'b0}}, idx} * {{IW{1'b0}}, idx};
    assign wdata     = DATA_W'(sq);
    assign we        = state == FILL;
    assign test_busy = state != IDLE;

    test022_ram #(.N(N), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (idx[AW-1:0]),
        .wdata (wdata),
        .rdata (rdata)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: SUM ends once idx has passed the last address and its word has landed
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = test_req ? FILL : IDLE;
            FILL:  state_nx = idx == LAST ? SUM : FILL;
            SUM:   state_nx = idx == NI ? CHECK : SUM;
            CHECK: state_nx = IDLE;
        endcase
    end

    // index, accumulator and result; rdata lags the address by one, so add whenever idx > 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            acc         <= '0;
            test_return <= 1'b0;
        end else begin
            case (state)
                IDLE: if (test_req) begin
                    idx <= '0;
                    acc <= '0;
                end
                FILL: idx <= idx == LAST ? '0 : idx + 1'b1;
                SUM: begin
                    if (idx != '0) acc <= acc + rdata;
                    if (idx != NI) idx <= idx + 1'b1;
                end
                CHECK: test_return <= acc == EXP_W;
            endcase
        end
    end

endmodule

// File: tb/tb_test022_selftest.sv
// tb_test022_selftest: directed checks of the self-test handshake on three parameterisations
module tb_test022_selftest;
    import test022_pkg::*;

    logic clk, reset;
    logic req0, busy0, ret0;
    logic req1, busy1, ret1;
    logic req2, busy2, ret2;
    int   n_cmp, n_bad;
    int   len, glitch;

    test022_selftest dut (
        .clk(clk), .reset(reset), .test_req(req0), .test_busy(busy0), .test_return(ret0)
    );

    test022_selftest #(.EXPECTED(1241)) dut_bad (
        .clk(clk), .reset(reset), .test_req(req1), .test_busy(busy1), .test_return(ret1)
    );

    test022_selftest #(.N(4), .EXPECTED(14)) dut4 (
        .clk(clk), .reset(reset), .test_req(req2), .test_busy(busy2), .test_return(ret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int s);
        return s == 0 ? busy0 : s == 1 ? busy1 : busy2;
    endfunction

    task automatic measure(input int s, output int l);
        l = 0;
        while (busy_of(s) && l < 200) begin
            l++;
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        req2 = 1'b0;
        repeat (5) step();
        chk("reset_busy", busy0, 0);
        chk("reset_ret", ret0, 0);
        chk("reset_ret_bad", ret1, 0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_busy", busy0, 0);
            chk("idle_ret", ret0, 0);
        end

        req0 = 1'b1;
        step();
        req0 = 1'b0;
        chk("single_busy_rise", busy0, 1);
        measure(0, len);
        chk("single_len", len, 34);
        chk("single_busy_fall", busy0, 0);
        chk("single_ret", ret0, 1);
        chk("golden_fn", int'(golden_sum(16)), 1240);

        repeat (3) step();
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        chk("hold_ret_at_start", ret0, 1);
        len = 0;
        while (busy0 && len < 200) begin
            len++;
            req0 = (len == 5 || len == 20);
            step();
        end
        req0 = 1'b0;
        chk("extra_req_len", len, 34);
        for (int c = 0; c < 4; c++) begin
            chk("extra_req_no_rerun", busy0, 0);
            step();
        end

        req0 = 1'b1;
        step();
        glitch = 0;
        for (int r = 0; r < 3; r++) begin
            len = 0;
            while (busy0 && len < 200) begin
                if (!ret0) glitch++;
                len++;
                step();
            end
            chk("held_len", len, 34);
            chk("held_gap_busy", busy0, 0);
            chk("held_gap_ret", ret0, 1);
            step();
            chk("held_restart", busy0, 1);
        end
        chk("held_glitch", glitch, 0);
        req0 = 1'b0;
        measure(0, len);
        chk("held_tail_len", len, 34);
        chk("held_tail_ret", ret0, 1);

        step();
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        repeat (14) step();
        chk("midrun_busy_before", busy0, 1);
        reset = 1'b0;
        #1;
        chk("midrun_busy", busy0, 0);
        chk("midrun_ret", ret0, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_reset_ret", ret0, 0);
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        measure(0, len);
        chk("post_reset_len", len, 34);
        chk("post_reset_ret_final", ret0, 1);

        req1 = 1'b1;
        step();
        req1 = 1'b0;
        measure(1, len);
        chk("bad_len", len, 34);
        chk("bad_ret", ret1, 0);

        req2 = 1'b1;
        step();
        req2 = 1'b0;
        measure(2, len);
        chk("n4_len", len, 10);
        chk("n4_ret", ret2, 1);
        chk("golden_fn_n4", int'(golden_sum(4)), 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
